// File: rtl/scroll_controller.sv
// Side-scroll camera controller: dead-zone follow, arena lock and recenter, with an optional screen shake.
// Optional feature macro: SCROLL_SHAKE_EN (vertical shake offset); when undefined offset is tied to 0.
module scroll_controller #(
    parameter logic [10:0] LEFT_EDGE    = 11'd160,
    parameter logic [10:0] RIGHT_EDGE   = 11'd400,
    parameter logic [10:0] MAX_STEP     = 11'd8,
    parameter logic [10:0] CAM_MIN      = 11'd5,
    parameter logic [10:0] CAM_MAX      = 11'd360,
    parameter logic [10:0] SHAKE_AMP    = 11'd4,
    parameter logic [5:0]  SHAKE_FRAMES = 6'd16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        enable,
    input  logic [10:0] player_x,
    input  logic        lock_req,
    input  logic        shake_req,
    output logic [10:0] roll,
    output logic [10:0] offset,
    output logic [10:0] cam_x,
    output logic [1:0]  state,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FOLLOW   = 2'd1,
        S_LOCKED   = 2'd2,
        S_RECENTER = 2'd3
    } state_t;

    localparam logic signed [11:0] C_LEFT    = {1'b0, LEFT_EDGE};
    localparam logic signed [11:0] C_RIGHT   = {1'b0, RIGHT_EDGE};
    localparam logic signed [11:0] C_STEP    = {1'b0, MAX_STEP};
    localparam logic signed [11:0] C_HALF    = {2'b00, MAX_STEP[10:1]};
    localparam logic signed [11:0] C_CAM_MIN = {1'b0, CAM_MIN};
    localparam logic signed [11:0] C_CAM_MAX = {1'b0, CAM_MAX};
    localparam logic signed [11:0] C_CENTER  = 12'sd320;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_frame_q;
    logic        r_frame_tick;
    logic [10:0] r_roll;
    logic [10:0] r_cam_x;
    logic [10:0] w_roll_next;
    logic [10:0] w_cam_next;

    logic signed [11:0] w_px;
    logic signed [11:0] w_cam;
    logic signed [11:0] w_follow_raw;
    logic signed [11:0] w_follow_sat;
    logic signed [11:0] w_center_diff;
    logic signed [11:0] w_center_sat;
    logic signed [11:0] w_raw;
    logic signed [11:0] w_sum;
    logic signed [11:0] w_clamped;
    logic               w_in_zone;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_state      <= S_IDLE;
            r_roll       <= '0;
            r_cam_x      <= CAM_MIN;
        end else begin
            r_frame_q    <= frame_clk;
            r_frame_tick <= frame_clk & ~r_frame_q;
            if (r_frame_tick) begin
                r_state <= w_state_next;
                r_roll  <= w_roll_next;
                r_cam_x <= w_cam_next;
            end
        end
    end

    // All signed math is 12-bit so player_x up to 2047 never wraps before clamping.
    always_comb begin
        w_px          = {1'b0, player_x};
        w_cam         = {1'b0, r_cam_x};
        w_in_zone     = (w_px >= C_LEFT) && (w_px <= C_RIGHT);

        w_follow_raw  = '0;
        if (w_px > C_RIGHT)
            w_follow_raw = w_px - C_RIGHT;
        else if (w_px < C_LEFT)
            w_follow_raw = w_px - C_LEFT;

        w_follow_sat  = w_follow_raw;
        if (w_follow_raw > C_STEP)
            w_follow_sat = C_STEP;
        else if (w_follow_raw < -C_STEP)
            w_follow_sat = -C_STEP;

        w_center_diff = C_CENTER - w_px;
        w_center_sat  = w_center_diff;
        if (w_center_diff > C_HALF)
            w_center_sat = C_HALF;
        else if (w_center_diff < -C_HALF)
            w_center_sat = -C_HALF;

        w_raw     = (r_state == S_RECENTER) ? w_center_sat : w_follow_sat;
        w_sum     = w_cam + w_raw;
        w_clamped = w_raw;
        if (w_sum > C_CAM_MAX)
            w_clamped = C_CAM_MAX - w_cam;
        else if (w_sum < C_CAM_MIN)
            w_clamped = C_CAM_MIN - w_cam;
    end

    always_comb begin
        w_state_next = r_state;
        w_roll_next  = '0;
        w_cam_next   = r_cam_x;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = lock_req ? S_LOCKED : S_FOLLOW;
                end
                S_FOLLOW: begin
                    if (lock_req) begin
                        w_state_next = S_LOCKED;
                    end else begin
                        w_roll_next = w_clamped[10:0];
                        w_cam_next  = r_cam_x + w_clamped[10:0];
                    end
                end
                S_LOCKED: begin
                    if (!lock_req)
                        w_state_next = S_RECENTER;
                end
                S_RECENTER: begin
                    if (lock_req) begin
                        w_state_next = S_LOCKED;
                    end else begin
                        w_roll_next = w_clamped[10:0];
                        w_cam_next  = r_cam_x + w_clamped[10:0];
                        if (w_in_zone || (w_clamped == 12'sd0))
                            w_state_next = S_FOLLOW;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

`ifdef SCROLL_SHAKE_EN
    logic [5:0]  r_shake_cnt;
    logic        r_shake_phase;
    logic [10:0] r_offset;

    // A request restarts the pattern at SHAKE_AMP; the final counted tick always lands on 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shake_cnt   <= '0;
            r_shake_phase <= 1'b0;
            r_offset      <= '0;
        end else if (shake_req) begin
            r_shake_cnt   <= SHAKE_FRAMES;
            r_shake_phase <= 1'b0;
        end else if (r_frame_tick) begin
            if (r_shake_cnt != 6'd0) begin
                r_shake_cnt   <= r_shake_cnt - 6'd1;
                r_shake_phase <= ~r_shake_phase;
                r_offset      <= (r_shake_phase || r_shake_cnt == 6'd1) ? 11'd0 : SHAKE_AMP;
            end else begin
                r_offset <= '0;
            end
        end
    end

    assign offset = r_offset;
`else
    logic w_unused_shake;
    assign w_unused_shake = ^{shake_req, SHAKE_AMP, SHAKE_FRAMES};
    assign offset = '0;
`endif

    assign roll       = r_roll;
    assign cam_x      = r_cam_x;
    assign state      = r_state;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench for scroll_controller: each frame pushes its expected outputs, a monitor checks them after every frame_tick.
module tb_scroll_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        enable;
    logic [10:0] player_x;
    logic        lock_req;
    logic        shake_req;
    logic [10:0] roll;
    logic [10:0] offset;
    logic [10:0] cam_x;
    logic [1:0]  state;
    logic        frame_tick;

    always #10 Clk = ~Clk;

    scroll_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .enable     (enable),
        .player_x   (player_x),
        .lock_req   (lock_req),
        .shake_req  (shake_req),
        .roll       (roll),
        .offset     (offset),
        .cam_x      (cam_x),
        .state      (state),
        .frame_tick (frame_tick)
    );

`ifdef SCROLL_SHAKE_EN
    localparam bit SHK = 1'b1;
`else
    localparam bit SHK = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] roll;
        logic [10:0] cam;
        logic [1:0]  st;
        logic [10:0] off;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_cnt = 0;
    int   frame_no = 0;

    function automatic void check(string name, logic [10:0] act, logic [10:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h)", name, act, act, exp, exp);
    endfunction

    // Monitor: a tick seen at one falling edge is applied at the next rising edge and compared after it.
    initial begin
        logic pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge Clk);
            if (pend) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tick: tick with no expected entry, state=%0d roll=0x%03h", state, roll);
                end else begin
                    e = q.pop_front();
                    frame_no++;
                    $display("frame %0d: roll=0x%03h cam_x=%0d state=%0d offset=%0d", frame_no, roll, cam_x, state, offset);
                    check("roll", roll, e.roll);
                    check("cam_x", cam_x, e.cam);
                    check("state", {9'd0, state}, {9'd0, e.st});
                    check("offset", offset, e.off);
                end
            end
            pend = frame_tick;
            if (frame_tick) tick_cnt++;
        end
    end

    task automatic frame(input logic [10:0] r, input logic [10:0] c, input logic [1:0] s, input logic [10:0] o);
        exp_t e;
        e.roll = r; e.cam = c; e.st = s; e.off = o;
        q.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pulse_shake();
        @(negedge Clk);
        shake_req = 1'b1;
        @(negedge Clk);
        shake_req = 1'b0;
    endtask

    initial begin
        int t0;
        exp_t e;
        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0;
        player_x = 11'd300; lock_req = 1'b0; shake_req = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_roll", roll, 11'd0);
        check("rst_offset", offset, 11'd0);
        check("rst_cam_x", cam_x, 11'd5);
        check("rst_state", {9'd0, state}, 11'd0);
        check("rst_tick", {10'd0, frame_tick}, 11'd0);
        Reset = 1'b0;

        // IDLE -> FOLLOW, dead zone
        enable = 1'b1;
        frame(11'd0, 11'd5, 2'd1, 11'd0);
        frame(11'd0, 11'd5, 2'd1, 11'd0);
        frame(11'd0, 11'd5, 2'd1, 11'd0);

        // Follow right and left, saturation and lower clamp
        player_x = 11'd420; frame(11'd8,     11'd13, 2'd1, 11'd0);
        player_x = 11'd405; frame(11'd5,     11'd18, 2'd1, 11'd0);
        player_x = 11'd100; frame(11'h7F8,   11'd10, 2'd1, 11'd0);
        player_x = 11'd150; frame(11'h7FB,   11'd5,  2'd1, 11'd0);
        player_x = 11'd159; frame(11'd0,     11'd5,  2'd1, 11'd0);
        player_x = 11'd405; frame(11'd5,     11'd10, 2'd1, 11'd0);

        // Walk right to 358, then upper clamp
        player_x = 11'd600;
        for (int i = 0; i < 43; i++)
            frame(11'd8, 11'(10 + 8 * (i + 1)), 2'd1, 11'd0);
        player_x = 11'd404; frame(11'd4, 11'd358, 2'd1, 11'd0);
        player_x = 11'd600; frame(11'd2, 11'd360, 2'd1, 11'd0);
        frame(11'd0, 11'd360, 2'd1, 11'd0);

        // Arena lock, release, recenter
        player_x = 11'd500; lock_req = 1'b1;
        repeat (4) frame(11'd0, 11'd360, 2'd2, 11'd0);
        lock_req = 1'b0;
        frame(11'd0,   11'd360, 2'd3, 11'd0);
        frame(11'h7FC, 11'd356, 2'd3, 11'd0);
        frame(11'h7FC, 11'd352, 2'd3, 11'd0);
        lock_req = 1'b1; frame(11'd0, 11'd352, 2'd2, 11'd0);
        lock_req = 1'b0; frame(11'd0, 11'd352, 2'd3, 11'd0);
        player_x = 11'd300; frame(11'd4, 11'd356, 2'd1, 11'd0);

        // enable=0 forces IDLE from any state, cam_x kept
        enable = 1'b0; player_x = 11'd600; frame(11'd0, 11'd356, 2'd0, 11'd0);
        enable = 1'b1; lock_req = 1'b1;    frame(11'd0, 11'd356, 2'd2, 11'd0);
        enable = 1'b0;                     frame(11'd0, 11'd356, 2'd0, 11'd0);

        // Shake pattern
        lock_req = 1'b0; player_x = 11'd300;
        pulse_shake();
        enable = 1'b1;
        for (int i = 0; i < 18; i++)
            frame(11'd0, 11'd356, 2'd1, (SHK && i < 16 && (i % 2) == 0) ? 11'd4 : 11'd0);

        // Reload mid-shake restarts at the amplitude
        pulse_shake();
        frame(11'd0, 11'd356, 2'd1, SHK ? 11'd4 : 11'd0);
        frame(11'd0, 11'd356, 2'd1, 11'd0);
        frame(11'd0, 11'd356, 2'd1, SHK ? 11'd4 : 11'd0);
        pulse_shake();
        frame(11'd0, 11'd356, 2'd1, SHK ? 11'd4 : 11'd0);

        // Reset mid-shake aborts on the next clock
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_offset", offset, 11'd0);
        check("midrst_state", {9'd0, state}, 11'd0);
        check("midrst_cam_x", cam_x, 11'd5);
        check("midrst_roll", roll, 11'd0);
        Reset = 1'b0;

        // frame_clk held high: one tick only, evaluated from IDLE
        t0 = tick_cnt;
        e.roll = 11'd0; e.cam = 11'd5; e.st = 2'd1; e.off = 11'd0;
        q.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check("held_high_ticks", 11'(tick_cnt - t0), 11'd1);

        repeat (4) @(negedge Clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL missing_ticks: %0d expected frames never observed, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scroll_controller.md
SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 SHALL have parameter LEFT_EDGE, default 11'd160: left dead-zone bound, screen pixels.
REQ-002 SHALL have parameter RIGHT_EDGE, default 11'd400: right dead-zone bound, screen pixels.
REQ-003 SHALL have parameter MAX_STEP, default 11'd8: maximum roll magnitude per frame.
REQ-004 SHALL have parameter CAM_MIN, default 11'd5: minimum tracked camera X.
REQ-005 SHALL have parameter CAM_MAX, default 11'd360: maximum tracked camera X (map 1000 minus screen 640).
REQ-006 SHALL have parameter SHAKE_AMP, default 11'd4: vertical shake offset amplitude.
REQ-007 SHALL have parameter SHAKE_FRAMES, default 6'd16: shake duration, frames.
REQ-008 SHALL have port Clk  in  1  50 MHz system clock; the only clock.
REQ-009 SHALL have port Reset  in  1  synchronous active-high reset.
REQ-010 SHALL have port frame_clk  in  1  frame strobe (~60 Hz), sampled as data on Clk.
REQ-011 SHALL have port enable  in  1  level; allows leaving IDLE.
REQ-012 SHALL have port player_x  in  11  player screen X.
REQ-013 SHALL have port lock_req  in  1  level; freezes scrolling (arena lock).
REQ-014 SHALL have port shake_req  in  1  single-cycle pulse; starts screen shake.
REQ-015 SHALL have port roll  out  11  signed two's-complement per-frame scroll delta.
REQ-016 SHALL have port offset  out  11  vertical background offset.
REQ-017 SHALL have port cam_x  out  11  tracked camera X.
REQ-018 SHALL have port state  out  2  FSM state: 0 IDLE, 1 FOLLOW, 2 LOCKED, 3 RECENTER.
REQ-019 SHALL have port frame_tick  out  1  one-Clk pulse per detected frame.

Function
REQ-020 SHALL register frame_clk into frame_q each Clk; frame_tick = frame_clk & ~frame_q, registered, so it asserts 1 Clk after the rising edge.
REQ-021 SHALL update roll, cam_x, state and the shake counter only in the cycle frame_tick is high; all hold otherwise.
REQ-022 IDLE: roll=0; goes to FOLLOW on a tick with enable=1 and lock_req=0; goes to LOCKED on a tick with enable=1 and lock_req=1.
REQ-023 FOLLOW: raw = player_x-RIGHT_EDGE if player_x>RIGHT_EDGE; -(LEFT_EDGE-player_x) if player_x<LEFT_EDGE; else 0; magnitude saturates at MAX_STEP.
REQ-024 SHALL clamp roll so cam_x+roll stays in [CAM_MIN, CAM_MAX], then set cam_x <= cam_x+roll in the same tick.
REQ-025 FOLLOW goes to LOCKED on a tick with lock_req=1, and that tick's roll=0.
REQ-026 LOCKED: roll=0; goes to RECENTER on a tick with lock_req=0.
REQ-027 RECENTER: roll = sign(320-player_x)*min(|320-player_x|, MAX_STEP/2), clamped per REQ-024.
REQ-028 RECENTER goes to FOLLOW when player_x is in [LEFT_EDGE, RIGHT_EDGE] or the clamp yields 0.
REQ-029 RECENTER goes to LOCKED if lock_req=1, with priority over REQ-028.
REQ-030 enable=0 on any tick SHALL force IDLE with roll=0; cam_x is retained.
REQ-031 All arithmetic SHALL be 12-bit signed internally; results truncate to 11 bits only after clamping.

Reset
REQ-032 Reset SHALL set roll=0, offset=0, cam_x=CAM_MIN, state=IDLE, frame_tick=0, frame_q=0 and the shake counter to 0, overriding all other inputs that cycle.
REQ-033 Reset mid-shake or mid-RECENTER SHALL abort immediately; the first tick after deassertion is evaluated from IDLE.

Configuration
REQ-034 Macro SCROLL_SHAKE_EN: when defined, a shake_req pulse (any state) loads the shake counter with SHAKE_FRAMES.
REQ-035 SCROLL_SHAKE_EN defined: each tick with counter>0, offset toggles between SHAKE_AMP and 0 (first tick SHAKE_AMP) and the counter decrements; offset=0 once the counter is 0.
REQ-036 SCROLL_SHAKE_EN defined: a shake_req during an active shake reloads the counter.
REQ-037 SCROLL_SHAKE_EN undefined: shake_req is ignored, offset is constant 0 and no counter logic is synthesized.

Verification
REQ-038 Reset, enable=1, player_x=300, 3 frame edges -> state IDLE->FOLLOW, roll=0 on each tick, cam_x=5.
REQ-039 FOLLOW, player_x=420 -> roll=+8 on the next tick, cam_x 5->13; player_x=405 -> roll=+5.
REQ-040 cam_x=358, player_x=600 -> roll=+2, cam_x=360; next tick roll=0.
REQ-041 lock_req=1 for 4 ticks, then 0 with player_x=500 -> LOCKED, roll=0 x4, then RECENTER with roll=-4 (0x7FC).
REQ-042 SCROLL_SHAKE_EN defined, shake_req pulse -> offset 4,0,4,0... for 16 ticks, then 0; with the macro undefined, offset stays 0.
REQ-043 frame_clk held high 1000 Clk -> exactly one frame_tick; Reset asserted mid-shake -> offset=0 and state=IDLE the next Clk.
